// File: rtl/dct_coef_engine.sv
// rtl/dct_coef_engine.sv - time-multiplexed 8-point DCT-II coefficient engine
// One MAC walks x[n]*C[k][n] over n; each finished sum is shifted, saturated and streamed out.
module dct_coef_engine #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [8*IN_W-1:0] s_data,
    input  logic              s_all,
    input  logic [2:0]        s_k,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic [2:0]        m_k,
    output logic              m_last,
    output logic              m_sat
);
    localparam int ACC_W = IN_W + COEF_W + 3;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_q, state_d;
    logic [8*IN_W-1:0]       x_q;
    logic                    all_q;
    logic [2:0]              k_q, k_d, n_q, n_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    m_valid_q, m_last_q, m_sat_q;
    logic [OUT_W-1:0]        m_data_q;
    logic [2:0]              m_k_q;
    logic                    load_in, load_out, clr_valid;

    int                       c;
    logic signed [COEF_W-1:0] coef;
    logic signed [IN_W-1:0]   x_n;
    logic signed [ACC_W-1:0]  prod, acc_sum, shifted;
    logic [ACC_W-OUT_W:0]     top;
    logic                     fits;
    logic [OUT_W-1:0]         sat_val;

    // Q2.14 basis; row k=0 (5793 everywhere) falls to the default arm.
    always_comb begin
        c = 0;
        case ({k_q, n_q})
            6'o10: c = 8035;  6'o11: c = 6811;  6'o12: c = 4551;  6'o13: c = 1598;
            6'o14: c = -1598; 6'o15: c = -4551; 6'o16: c = -6811; 6'o17: c = -8035;
            6'o20: c = 7568;  6'o21: c = 3135;  6'o22: c = -3135; 6'o23: c = -7568;
            6'o24: c = -7568; 6'o25: c = -3135; 6'o26: c = 3135;  6'o27: c = 7568;
            6'o30: c = 6811;  6'o31: c = -1598; 6'o32: c = -8035; 6'o33: c = -4551;
            6'o34: c = 4551;  6'o35: c = 8035;  6'o36: c = 1598;  6'o37: c = -6811;
            6'o40: c = 5793;  6'o41: c = -5793; 6'o42: c = -5793; 6'o43: c = 5793;
            6'o44: c = 5793;  6'o45: c = -5793; 6'o46: c = -5793; 6'o47: c = 5793;
            6'o50: c = 4551;  6'o51: c = -8035; 6'o52: c = 1598;  6'o53: c = 6811;
            6'o54: c = -6811; 6'o55: c = -1598; 6'o56: c = 8035;  6'o57: c = -4551;
            6'o60: c = 3135;  6'o61: c = -7568; 6'o62: c = 7568;  6'o63: c = -3135;
            6'o64: c = -3135; 6'o65: c = 7568;  6'o66: c = -7568; 6'o67: c = 3135;
            6'o70: c = 1598;  6'o71: c = -4551; 6'o72: c = 6811;  6'o73: c = -8035;
            6'o74: c = 8035;  6'o75: c = -6811; 6'o76: c = 4551;  6'o77: c = -1598;
            default: c = 5793;
        endcase
        coef = COEF_W'(c);
    end

    // Operands are sign-extended to ACC_W so the truncated product is the exact signed result.
    always_comb begin
        x_n     = x_q[n_q*IN_W +: IN_W];
        prod    = {{(ACC_W-IN_W){x_n[IN_W-1]}}, x_n} * {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
        acc_sum = acc_q + prod;
        shifted = acc_sum >>> SHIFT;
        top     = shifted[ACC_W-1:OUT_W-1];
        fits    = (&top) | ~(|top);
        sat_val = fits ? shifted[OUT_W-1:0]
                       : {shifted[ACC_W-1], {(OUT_W-1){~shifted[ACC_W-1]}}};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        n_d       = n_q;
        k_d       = k_q;
        load_in   = 1'b0;
        load_out  = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    load_in = 1'b1;
                    k_d     = s_all ? 3'd0 : s_k;
                    acc_d   = '0;
                    n_d     = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                n_d   = n_q + 3'd1;
                if (n_q == 3'd7) begin
                    load_out = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    clr_valid = 1'b1;
                    if (m_last_q) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 3'd1;
                        acc_d   = '0;
                        n_d     = 3'd0;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            all_q     <= 1'b0;
            k_q       <= 3'd0;
            n_q       <= 3'd0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_k_q     <= 3'd0;
            m_last_q  <= 1'b0;
            m_sat_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            if (load_in) begin
                x_q   <= s_data;
                all_q <= s_all;
            end
            if (load_out) begin
                m_valid_q <= 1'b1;
                m_data_q  <= sat_val;
                m_sat_q   <= ~fits;
                m_k_q     <= k_q;
                m_last_q  <= ~all_q | (k_q == 3'd7);
            end else if (clr_valid) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign s_ready = (state_q == IDLE) && !rst;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_k     = m_k_q;
    assign m_last  = m_last_q;
    assign m_sat   = m_sat_q;
endmodule
